// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the two-client RAM access sequencer.
//   state_t            : sequencer FSM states
//   CLIENT_VIDEO/LOADER: client index constants
//   WRITE_HOLD         : cycles the write strobe stays high
//   DEF_TIMEOUT_CYCLES : default read-wait limit
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STROBE  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int unsigned N_CLIENTS          = 2;
    localparam int unsigned CLIENT_VIDEO       = 0;
    localparam int unsigned CLIENT_LOADER      = 1;
    localparam int unsigned WRITE_HOLD         = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/ram_ctrl_arb.sv
// 2-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-client request vector
//   en       : grant is being taken this cycle (updates the pointer)
//   grant_c  : combinational one-hot grant
module ram_ctrl_arb
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant_c
);

    // Index of the client granted most recently
    logic last;

    // On a tie, favour the client that was not served last
    always_comb begin
        grant_c = req;
        if (req == 2'b11) begin
            grant_c = (last == 1'(CLIENT_LOADER)) ? 2'(1 << CLIENT_VIDEO)
                                                  : 2'(1 << CLIENT_LOADER);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'(CLIENT_LOADER);
        end else if (en && (grant_c != 2'b00)) begin
            last <= grant_c[1];
        end
    end

endmodule

// File: rtl/ram_ctrl.sv
// Two-client access sequencer in front of the edge-triggered game RAM.
// Accepts one request at a time, drives the RAM strobe for the required
// time, returns read data with a valid pulse, then forces one strobe-low
// cycle so every access presents a fresh rising edge.
// Optional feature macro: RAM_CTRL_TIMEOUT_EN (read-wait timeout, o_err).
// Ports:
//   i_clk, i_rst                      : clock, synchronous active-high reset
//   i_req, i_we                       : per-client request / write select
//   i_addr0/1, i_wdata0/1             : per-client address / write data
//   o_ack, o_rvalid                   : per-client accept / read-data pulses
//   o_rdata, o_err, o_busy            : read data, timeout flag, not-idle
//   o_ram_read, o_ram_write           : RAM strobes (levels)
//   o_ram_read_addr/write_addr/wdata  : RAM address and data
//   i_ram_data, i_ram_valid           : RAM read return
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_CLIENTS-1:0] i_req,
    input  logic [N_CLIENTS-1:0] i_we,
    input  logic [ADDR_W-1:0]    i_addr0,
    input  logic [ADDR_W-1:0]    i_addr1,
    input  logic [DATA_W-1:0]    i_wdata0,
    input  logic [DATA_W-1:0]    i_wdata1,
    output logic [N_CLIENTS-1:0] o_ack,
    output logic [N_CLIENTS-1:0] o_rvalid,
    output logic [DATA_W-1:0]    o_rdata,
    output logic                 o_err,
    output logic                 o_busy,
    output logic                 o_ram_read,
    output logic                 o_ram_write,
    output logic [ADDR_W-1:0]    o_ram_read_addr,
    output logic [ADDR_W-1:0]    o_ram_write_addr,
    output logic [DATA_W-1:0]    o_ram_wdata,
    input  logic [DATA_W-1:0]    i_ram_data,
    input  logic                 i_ram_valid
);

    localparam int unsigned HOLD_W = (WRITE_HOLD > 2) ? $clog2(WRITE_HOLD) : 1;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    state_t                state, state_nxt;
    logic                  cmd_we, we_nxt;
    logic                  cmd_client, client_nxt;
    logic [HOLD_W-1:0]     hold_cnt, hold_nxt;
    logic [N_CLIENTS-1:0]  ack_nxt, rvalid_nxt;
    logic [DATA_W-1:0]     rdata_nxt, wdata_nxt;
    logic [ADDR_W-1:0]     raddr_nxt, waddr_nxt;
    logic                  read_nxt, write_nxt, busy_nxt;
    logic                  arb_en;
    logic [1:0]            grant_c;

`ifdef RAM_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic             err_nxt;
`else
    assign o_err = 1'b0;
`endif

    ram_ctrl_arb u_arb (
        .clk     (i_clk),
        .rst     (i_rst),
        .req     (i_req),
        .en      (arb_en),
        .grant_c (grant_c)
    );

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= ST_IDLE;
            cmd_we           <= 1'b0;
            cmd_client       <= 1'b0;
            hold_cnt         <= '0;
            o_ack            <= '0;
            o_rvalid         <= '0;
            o_rdata          <= '0;
            o_busy           <= 1'b0;
            o_ram_read       <= 1'b0;
            o_ram_write      <= 1'b0;
            o_ram_read_addr  <= '0;
            o_ram_write_addr <= '0;
            o_ram_wdata      <= '0;
`ifdef RAM_CTRL_TIMEOUT_EN
            tmo_cnt          <= '0;
            o_err            <= 1'b0;
`endif
        end else begin
            state            <= state_nxt;
            cmd_we           <= we_nxt;
            cmd_client       <= client_nxt;
            hold_cnt         <= hold_nxt;
            o_ack            <= ack_nxt;
            o_rvalid         <= rvalid_nxt;
            o_rdata          <= rdata_nxt;
            o_busy           <= busy_nxt;
            o_ram_read       <= read_nxt;
            o_ram_write      <= write_nxt;
            o_ram_read_addr  <= raddr_nxt;
            o_ram_write_addr <= waddr_nxt;
            o_ram_wdata      <= wdata_nxt;
`ifdef RAM_CTRL_TIMEOUT_EN
            tmo_cnt          <= tmo_nxt;
            o_err            <= err_nxt;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        we_nxt     = cmd_we;
        client_nxt = cmd_client;
        hold_nxt   = hold_cnt;
        ack_nxt    = '0;
        rvalid_nxt = '0;
        rdata_nxt  = o_rdata;
        read_nxt   = o_ram_read;
        write_nxt  = o_ram_write;
        raddr_nxt  = o_ram_read_addr;
        waddr_nxt  = o_ram_write_addr;
        wdata_nxt  = o_ram_wdata;
        arb_en     = 1'b0;
`ifdef RAM_CTRL_TIMEOUT_EN
        tmo_nxt    = tmo_cnt;
        err_nxt    = 1'b0;
`endif

        unique case (state)
            ST_IDLE: begin
                if (grant_c != 2'b00) begin
                    arb_en     = 1'b1;
                    client_nxt = grant_c[1];
                    we_nxt     = i_we[grant_c[1]];
                    ack_nxt    = grant_c;
                    hold_nxt   = '0;
`ifdef RAM_CTRL_TIMEOUT_EN
                    tmo_nxt    = '0;
`endif
                    if (i_we[grant_c[1]]) begin
                        write_nxt = 1'b1;
                        waddr_nxt = grant_c[1] ? i_addr1 : i_addr0;
                        wdata_nxt = grant_c[1] ? i_wdata1 : i_wdata0;
                    end else begin
                        read_nxt  = 1'b1;
                        raddr_nxt = grant_c[1] ? i_addr1 : i_addr0;
                    end
                    state_nxt = ST_STROBE;
                end
            end

            ST_STROBE: begin
                if (cmd_we) begin
                    // RAM latches address on the first edge, data on the last
                    if (hold_cnt == HOLD_W'(WRITE_HOLD - 1)) begin
                        write_nxt = 1'b0;
                        state_nxt = ST_RELEASE;
                    end else begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end
                end else if (i_ram_valid) begin
                    rdata_nxt              = i_ram_data;
                    rvalid_nxt[cmd_client] = 1'b1;
                    read_nxt               = 1'b0;
                    state_nxt              = ST_RELEASE;
                end
`ifdef RAM_CTRL_TIMEOUT_EN
                // Valid on the timeout edge takes priority (branch above)
                else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_nxt              = '0;
                    rvalid_nxt[cmd_client] = 1'b1;
                    err_nxt                = 1'b1;
                    read_nxt               = 1'b0;
                    state_nxt              = ST_RELEASE;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
`endif
            end

            ST_RELEASE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: randomized two-client traffic against a
// memory-array reference model, with a queue-based scoreboard and a monitor
// that checks acks, read returns and RAM strobe shape.
`timescale 1ns/1ps
module tb_ram_ctrl;

    localparam int TMO = 15;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [1:0] i_req = 2'b00;
    logic [1:0] i_we = 2'b00;
    logic [7:0] i_addr0 = 8'h00, i_addr1 = 8'h00;
    logic [7:0] i_wdata0 = 8'h00, i_wdata1 = 8'h00;
    logic [1:0] o_ack, o_rvalid;
    logic [7:0] o_rdata;
    logic       o_err, o_busy, o_ram_read, o_ram_write;
    logic [7:0] o_ram_read_addr, o_ram_write_addr, o_ram_wdata;
    logic [7:0] i_ram_data = 8'h00;
    logic       i_ram_valid = 1'b0;

    ram_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_req            (i_req),
        .i_we             (i_we),
        .i_addr0          (i_addr0),
        .i_addr1          (i_addr1),
        .i_wdata0         (i_wdata0),
        .i_wdata1         (i_wdata1),
        .o_ack            (o_ack),
        .o_rvalid         (o_rvalid),
        .o_rdata          (o_rdata),
        .o_err            (o_err),
        .o_busy           (o_busy),
        .o_ram_read       (o_ram_read),
        .o_ram_write      (o_ram_write),
        .o_ram_read_addr  (o_ram_read_addr),
        .o_ram_write_addr (o_ram_write_addr),
        .o_ram_wdata      (o_ram_wdata),
        .i_ram_data       (i_ram_data),
        .i_ram_valid      (i_ram_valid)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // ---------------- RAM model (edge-triggered strobes) ----------------
    logic [7:0] ram_mem [256] = '{default: 8'h00};
    logic       rd_prev = 1'b0, wr_prev = 1'b0, rd_pend = 1'b0;
    logic [7:0] rd_addr_lat = 8'h00, wr_addr_lat = 8'h00;
    bit         ram_mute = 1'b0;

    always @(posedge i_clk) begin
        i_ram_valid <= 1'b0;
        if (rd_pend) begin
            i_ram_valid <= !ram_mute;
            i_ram_data  <= ram_mem[rd_addr_lat];
            rd_pend     <= 1'b0;
        end
        if (o_ram_read && !rd_prev) begin
            rd_pend     <= 1'b1;
            rd_addr_lat <= o_ram_read_addr;
        end
        if (o_ram_write && !wr_prev) wr_addr_lat <= o_ram_write_addr;
        else if (o_ram_write && wr_prev) ram_mem[wr_addr_lat] <= o_ram_wdata;
        rd_prev <= o_ram_read;
        wr_prev <= o_ram_write;
    end

    // ---------------- scoreboard ----------------
    typedef struct { int client; logic [7:0] data; logic err; int lat; } rd_exp_t;
    typedef struct { logic [7:0] addr; logic [7:0] data; } wr_exp_t;

    int         ack_q[$];
    rd_exp_t    rd_q[$];
    wr_exp_t    wr_q[$];
    logic [7:0] raddr_q[$];

    logic [7:0] ref_mem [256] = '{default: 8'h00};
    int         last_grant = 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- monitor ----------------
    bit      m_wprev = 1'b0, m_rprev = 1'b0;
    int      w_len = 0;
    int      ack_cyc = 0;
    wr_exp_t cur_wr;

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_ack != 2'b00) begin
                if (ack_q.size() == 0) chk("ack_unexpected", 32'(o_ack), 32'(0));
                else begin
                    int e;
                    e = ack_q.pop_front();
                    chk("ack_client", 32'(o_ack), 32'(1 << e));
                    ack_cyc = cyc;
                end
            end
            if (o_rvalid != 2'b00) begin
                if (rd_q.size() == 0) chk("rvalid_unexpected", 32'(o_rvalid), 32'(0));
                else begin
                    rd_exp_t r;
                    r = rd_q.pop_front();
                    chk("rvalid_client", 32'(o_rvalid), 32'(1 << r.client));
                    chk("rdata", 32'(o_rdata), 32'(r.data));
                    chk("err", 32'(o_err), 32'(r.err));
                    chk("read_latency", 32'(cyc - ack_cyc), 32'(r.lat));
                end
            end
            if (o_ram_write && !m_wprev) begin
                chk("write_gap", {30'd0, m_rprev || o_ram_read, m_wprev}, 32'(0));
                w_len = 1;
                if (wr_q.size() == 0) chk("write_unexpected", 32'(1), 32'(0));
                else begin
                    cur_wr = wr_q.pop_front();
                    chk("write_addr", 32'(o_ram_write_addr), 32'(cur_wr.addr));
                    chk("write_data", 32'(o_ram_wdata), 32'(cur_wr.data));
                end
            end else if (o_ram_write) begin
                w_len++;
            end
            if (!o_ram_write && m_wprev) begin
                chk("write_width", 32'(w_len), 32'(2));
                chk("ram_content", 32'(ram_mem[cur_wr.addr]), 32'(cur_wr.data));
            end
            if (o_ram_read && !m_rprev) begin
                chk("read_gap", {30'd0, m_wprev || o_ram_write, m_rprev}, 32'(0));
                if (raddr_q.size() == 0) chk("read_unexpected", 32'(1), 32'(0));
                else chk("read_addr", 32'(o_ram_read_addr), 32'(raddr_q.pop_front()));
            end
        end
        m_wprev = o_ram_write;
        m_rprev = o_ram_read;
    end

    // ---------------- stimulus helpers ----------------
    // Reference: round-robin order and memory effects of one request set
    task automatic model_push(input int c, input bit we, input logic [7:0] addr,
                              input logic [7:0] data, input bit tmo);
        ack_q.push_back(c);
        if (we) begin
            ref_mem[addr] = data;
            wr_q.push_back('{addr, data});
        end else begin
            raddr_q.push_back(addr);
            if (tmo) rd_q.push_back('{c, 8'h00, 1'b1, TMO});
            else     rd_q.push_back('{c, ref_mem[addr], 1'b0, 3});
        end
        last_grant = c;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge i_clk);
            if (!o_busy) break;
        end
        if (k == 200) chk("idle_timeout", 32'(1), 32'(0));
    endtask

    task automatic issue(input logic [1:0] mask, input logic [1:0] we,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1, input bit tmo);
        int first;
        logic [1:0] pending;
        int k;
        if (mask == 2'b11) begin
            first = (last_grant == 1) ? 0 : 1;
            model_push(first, we[first], first ? a1 : a0, first ? d1 : d0, tmo);
            model_push(1 - first, we[1 - first], first ? a0 : a1, first ? d0 : d1, tmo);
        end else begin
            first = mask[1] ? 1 : 0;
            model_push(first, we[first], first ? a1 : a0, first ? d1 : d0, tmo);
        end
        i_we = we; i_addr0 = a0; i_addr1 = a1; i_wdata0 = d0; i_wdata1 = d1;
        i_req = mask;
        pending = mask;
        for (k = 0; k < 100 && pending != 2'b00; k++) begin
            @(negedge i_clk);
            pending = pending & ~o_ack;
            i_req = pending;
        end
        if (pending != 2'b00) chk("ack_timeout", 32'(pending), 32'(0));
        i_req = 2'b00;
        wait_idle();
    endtask

    // Client 1 keeps i_req high and streams writes
    task automatic b2b(input int n);
        int prev_ack = 0;
        logic [7:0] a, d;
        a = 8'h40 + 8'($urandom_range(0, 15)); d = 8'($urandom);
        model_push(1, 1'b1, a, d, 1'b0);
        i_we = 2'b10; i_addr1 = a; i_wdata1 = d; i_req = 2'b10;
        for (int i = 0; i < n; i++) begin
            int k;
            for (k = 0; k < 50; k++) begin
                @(negedge i_clk);
                if (o_ack[1]) break;
            end
            if (k == 50) begin
                chk("b2b_ack_timeout", 32'(1), 32'(0));
                break;
            end
            if (i > 0) chk("b2b_period", 32'(cyc - prev_ack), 32'(4));
            prev_ack = cyc;
            if (i < n - 1) begin
                a = 8'h40 + 8'(i + 1); d = 8'($urandom);
                model_push(1, 1'b1, a, d, 1'b0);
                i_addr1 = a; i_wdata1 = d;
            end
        end
        i_req = 2'b00;
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {o_ack, o_rvalid, o_rdata, o_err, o_busy, o_ram_read, o_ram_write,
                   o_ram_read_addr, o_ram_write_addr != 8'h00, o_ram_wdata != 8'h00},
            32'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset_values");
        i_rst = 1'b0;
        @(negedge i_clk);

        // Loader writes 0xA5 to 0x10, video reads it back
        issue(2'b10, 2'b10, 8'h00, 8'h10, 8'h00, 8'hA5, 1'b0);
        issue(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0);

        // Simultaneous requests
        for (int i = 0; i < 4; i++)
            issue(2'b11, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)),
                  8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'b0);

        b2b(5);

        // Reset during the second strobe cycle of a read
        ack_q.push_back(0);
        raddr_q.push_back(8'h10);
        i_we = 2'b00; i_addr0 = 8'h10; i_req = 2'b01;
        begin
            int k;
            for (k = 0; k < 50; k++) begin
                @(negedge i_clk);
                if (o_ack[0]) break;
            end
            if (k == 50) chk("rst_ack_timeout", 32'(1), 32'(0));
        end
        i_req = 2'b00;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_reset_outputs("mid_read_reset");
        i_rst = 1'b0;
        last_grant = 1;
        repeat (3) @(negedge i_clk);

        // Normal service after reset
        issue(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0);
        issue(2'b11, 2'b01, 8'h20, 8'h10, 8'h3C, 8'h00, 1'b0);

`ifdef RAM_CTRL_TIMEOUT_EN
        ram_mute = 1'b1;
        issue(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1);
        ram_mute = 1'b0;
`endif

        for (int i = 0; i < 40; i++)
            issue(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                  8'($urandom), 8'($urandom), 1'b0);

        repeat (5) @(negedge i_clk);
        chk("queues_drained", 32'(ack_q.size() + rd_q.size() + wr_q.size() + raddr_q.size()),
            32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
